// File: rtl/gate_cycle_meter.sv
// -----------------------------------------------------------------------------
// gate_cycle_meter
//
// Measuring end of the gate-pulse scheme. A single-shot gate pulse timed in a
// foreign clock domain is synchronised into clk. The block counts how many clk
// cycles the synchronised gate stays high and presents that count on a
// valid/ready result interface. The count can be set against the reference
// period that timed the gate to compare clk with the reference clock.
//
// Optional feature (compile-time macro GATE_TIMEOUT_EN):
//   Defined     - a wait counter limits the time spent waiting for a rising
//                 edge to TIMEOUT cycles. When the limit is reached the block
//                 reports result=0 with timeout=1. The timeout port exists.
//   Undefined   - no wait counter and no timeout port. The block waits for a
//                 rising edge indefinitely.
//
// Parameters:
//   WIDTH        width of the count and of result; the count saturates at
//                2^WIDTH-1
//   SYNC_STAGES  flops in the gate_in synchroniser (2 or more)
//   TIMEOUT      wait-cycle limit (used only with GATE_TIMEOUT_EN)
//
// Ports:
//   clk           measured clock; every register is in this domain
//   resetn        asynchronous active-low reset
//   gate_in       gate pulse from the foreign domain, asynchronous to clk
//   start         single-cycle arm request, sampled only in IDLE
//   busy          high while armed or counting
//   result        number of clk cycles the synchronised gate was high
//   result_valid  result is available
//   result_ready  consumer accepts the result
//   overflow      count saturated; qualified by result_valid
//   timeout       no rising edge within TIMEOUT cycles; qualified by
//                 result_valid (GATE_TIMEOUT_EN only)
// -----------------------------------------------------------------------------
module gate_cycle_meter #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 65535
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             gate_in,
  input  logic             start,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             overflow
`ifdef GATE_TIMEOUT_EN
  ,
  output logic             timeout
`endif
);

  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("gate_cycle_meter: SYNC_STAGES must be at least 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("gate_cycle_meter: TIMEOUT must be at least 1");
  end

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_RISE,
    COUNT,
    DONE
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     count;
  logic [SYNC_STAGES-1:0] sync_p;
  logic                 gate_s;
  logic                 wait_hit;

  // Saturating increment: the count sticks at its maximum value.
  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end
    return v + WIDTH'(1);
  endfunction

  // ---- stage: gate_in synchroniser (gate_in is used nowhere else) ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_p <= '0;
    end else begin
      sync_p <= {sync_p[SYNC_STAGES-2:0], gate_in};
    end
  end

  assign gate_s = sync_p[SYNC_STAGES-1];

`ifdef GATE_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  logic [WAIT_W-1:0] wait_cnt;

  // Counts cycles spent in ARM and WAIT_RISE; cleared when the block is armed.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wait_cnt <= '0;
    end else if (state == IDLE && start) begin
      wait_cnt <= '0;
    end else if (state == ARM || state == WAIT_RISE) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  // The cycle that would bring the wait count up to TIMEOUT ends the wait.
  assign wait_hit = (wait_cnt == WAIT_LAST);
`else
  assign wait_hit = 1'b0;
`endif

  // ---- stage: measurement FSM, all outputs registered ----
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      count        <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      overflow     <= 1'b0;
      busy         <= 1'b0;
`ifdef GATE_TIMEOUT_EN
      timeout      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= ARM;
            count    <= '0;
            overflow <= 1'b0;
            busy     <= 1'b1;
`ifdef GATE_TIMEOUT_EN
            timeout  <= 1'b0;
`endif
          end
        end

        // Any pulse already high when start arrives is allowed to finish
        // unmeasured, so a partial pulse is never counted.
        ARM: begin
          if (wait_hit) begin
            state        <= DONE;
            result       <= '0;
            result_valid <= 1'b1;
            busy         <= 1'b0;
`ifdef GATE_TIMEOUT_EN
            timeout      <= 1'b1;
`endif
          end else if (!gate_s) begin
            state <= WAIT_RISE;
          end
        end

        // A rising edge seen on the final wait cycle still wins.
        WAIT_RISE: begin
          if (gate_s) begin
            state <= COUNT;
            count <= WIDTH'(1);
          end else if (wait_hit) begin
            state        <= DONE;
            result       <= '0;
            result_valid <= 1'b1;
            busy         <= 1'b0;
`ifdef GATE_TIMEOUT_EN
            timeout      <= 1'b1;
`endif
          end
        end

        COUNT: begin
          if (gate_s) begin
            if (count == CNT_MAX) begin
              overflow <= 1'b1;
            end
            count <= sat_inc(count);
          end else begin
            state        <= DONE;
            result       <= count;
            result_valid <= 1'b1;
            busy         <= 1'b0;
          end
        end

        // result/overflow/timeout stay frozen until the handshake; start and
        // gate activity are ignored here.
        DONE: begin
          if (result_ready) begin
            state        <= IDLE;
            result_valid <= 1'b0;
          end
        end

        default: begin
          state        <= IDLE;
          result_valid <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_cycle_meter.sv
// -----------------------------------------------------------------------------
// tb_gate_cycle_meter
//
// Two instances (WIDTH=32 and WIDTH=4) share one stimulus stream. Each issued
// measurement pushes its expected outcome into a queue; a monitor pops and
// checks whenever a new result appears, checks hold-stability while waiting
// for result_ready, and checks the handshake. Inputs are driven on the falling
// edge; outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_gate_cycle_meter;

  localparam int SS = 2;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        gate_in = 1'b0;
  logic        start = 1'b0;
  logic        result_ready = 1'b0;

  logic        busy_a, rv_a, ovf_a;
  logic [31:0] res_a;
  logic        busy_b, rv_b, ovf_b;
  logic [3:0]  res_b;
`ifdef GATE_TIMEOUT_EN
  logic        to_a, to_b;
`endif

  gate_cycle_meter #(.WIDTH(32), .SYNC_STAGES(SS), .TIMEOUT(TO)) dut_a (
    .clk(clk), .resetn(resetn), .gate_in(gate_in), .start(start),
    .busy(busy_a), .result(res_a), .result_valid(rv_a),
    .result_ready(result_ready), .overflow(ovf_a)
`ifdef GATE_TIMEOUT_EN
    , .timeout(to_a)
`endif
  );

  gate_cycle_meter #(.WIDTH(4), .SYNC_STAGES(SS), .TIMEOUT(TO)) dut_b (
    .clk(clk), .resetn(resetn), .gate_in(gate_in), .start(start),
    .busy(busy_b), .result(res_b), .result_valid(rv_b),
    .result_ready(result_ready), .overflow(ovf_b)
`ifdef GATE_TIMEOUT_EN
    , .timeout(to_b)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int pushes = 0;
  int handshakes = 0;

  typedef struct {
    int n;        // gate high length in cycles at the synchronised gate
    bit to;       // measurement expected to end by timeout
    int exp_cyc;  // cycle count at which result_valid must first be seen
  } exp_t;

  exp_t q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: a pulse of n cycles reads as n, clipped to the counter's max.
  function automatic int model_res(input int n, input bit to, input int maxv);
    if (to) return 0;
    return (n > maxv) ? maxv : n;
  endfunction

  function automatic bit model_ovf(input int n, input bit to, input int maxv);
    return !to && (n > maxv);
  endfunction

  // ---------------------------------------------------------------- monitor
  initial begin : monitor
    bit          prev_v;
    logic [31:0] hold_a;
    logic [3:0]  hold_b;
    logic        hold_oa, hold_ob;
    exp_t        e;
    prev_v = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!prev_v && rv_a) begin
        chk("valid_pair", rv_b, 1);
        chk("queue_nonempty", q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("latency", cyc, e.exp_cyc);
          chk("res32", res_a, model_res(e.n, e.to, 32'h7fffffff));
          chk("ovf32", ovf_a, model_ovf(e.n, e.to, 32'h7fffffff));
          chk("res4", res_b, model_res(e.n, e.to, 15));
          chk("ovf4", ovf_b, model_ovf(e.n, e.to, 15));
`ifdef GATE_TIMEOUT_EN
          chk("timeout32", to_a, e.to);
          chk("timeout4", to_b, e.to);
`endif
        end
        hold_a = res_a; hold_b = res_b; hold_oa = ovf_a; hold_ob = ovf_b;
      end else if (prev_v && result_ready) begin
        handshakes++;
        chk("valid_drop", rv_a, 0);
      end else if (prev_v) begin
        chk("valid_held", rv_a, 1);
        chk("hold_res32", res_a, hold_a);
        chk("hold_res4", res_b, hold_b);
        chk("hold_ovf", {hold_oa, hold_ob} == {ovf_a, ovf_b}, 1);
      end
      prev_v = rv_a;
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 200 && !rv_a; i++) tick(1);
    chk("valid_wait", rv_a, 1);
  endtask

  task automatic handshake(input int ready_dly, input bit extra, input bit hs_start);
    chk("busy_done", busy_a, 0);
    if (extra) begin
      gate_in = 1'b1;
      tick(2);
      gate_in = 1'b0;
      tick((ready_dly > 2) ? ready_dly - 2 : 1);
    end else begin
      tick(ready_dly);
    end
    result_ready = 1'b1;
    start = hs_start;
    tick(1);
    result_ready = 1'b0;
    start = 1'b0;
    tick(1);
    chk("idle_busy", busy_a, 0);
    chk("idle_valid", rv_a, 0);
  endtask

  // Assumes a falling edge, DUT in IDLE, gate low for at least 3 cycles.
  // pre_len>0: gate already high before start, staying high pre_len cycles
  // counted from the start cycle; that pulse must be discarded.
  task automatic run_txn(input int n, input int pre_len, input int ready_dly,
                         input bit extra, input bit hs_start);
    exp_t e;
    if (pre_len > 0) begin
      gate_in = 1'b1;
      tick(3);
    end
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("busy_armed", busy_a, 1);
    if (pre_len > 0) begin
      tick(pre_len - 1);
      gate_in = 1'b0;
      tick(2 + $urandom_range(0, 1));
    end else begin
      tick($urandom_range(0, 3));
    end
    gate_in = 1'b1;
    tick(n);
    gate_in = 1'b0;
    e.n = n; e.to = 1'b0; e.exp_cyc = cyc + SS + 1;
    q.push_back(e);
    pushes++;
    wait_valid();
    handshake(ready_dly, extra, hs_start);
    chk("result_kept", res_a, n);
    tick(3);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    #2 resetn = 1'b0;
    tick(2);
    chk("rst_busy", busy_a, 0);
    chk("rst_valid", rv_a, 0);
    chk("rst_res", res_a, 0);
    chk("rst_ovf", ovf_a, 0);
    resetn = 1'b1;
    tick(4);

    run_txn(10, 0, 0, 0, 0);   // plain 10-cycle pulse
    run_txn(5, 7, 1, 0, 0);    // pulse in progress at start is discarded
    run_txn(20, 0, 2, 0, 0);   // saturates the 4-bit instance
    run_txn(6, 0, 8, 1, 0);    // consumer stalls; pulse during DONE ignored
    run_txn(3, 0, 0, 0, 1);    // start in the handshake cycle is ignored
    run_txn(1, 0, 1, 0, 0);    // shortest pulse
    run_txn(15, 0, 0, 0, 0);   // exactly the 4-bit maximum, no overflow
    run_txn(16, 0, 0, 0, 0);   // one past the 4-bit maximum

    // Reset while counting: everything clears, nothing is reported.
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);
    gate_in = 1'b1;
    tick(8);
    resetn = 1'b0;
    #1;
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_valid", rv_a, 0);
    chk("mid_rst_res", res_a, 0);
    chk("mid_rst_res4", res_b, 0);
    chk("mid_rst_ovf", ovf_b, 0);
    gate_in = 1'b0;
    tick(2);
    resetn = 1'b1;
    tick(4);
    run_txn(4, 0, 1, 0, 0);

`ifdef GATE_TIMEOUT_EN
    begin
      exp_t e;
      start = 1'b1;
      e.n = 0; e.to = 1'b1; e.exp_cyc = cyc + 1 + TO;
      q.push_back(e);
      pushes++;
      tick(1);
      start = 1'b0;
      wait_valid();
      handshake(1, 0, 0);
      tick(3);
    end
`endif

    for (int k = 0; k < 25; k++) begin
      int n, pre, rd;
      bit ex;
      n   = $urandom_range(1, 24);
      pre = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 4)) : 0;
      rd  = $urandom_range(0, 6);
      ex  = (rd >= 3) && ($urandom_range(0, 1) == 1);
      run_txn(n, pre, rd, ex, $urandom_range(0, 1) == 1);
    end

    tick(5);
    chk("queue_drained", q.size(), 0);
    chk("handshake_count", handshakes, pushes);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gate_cycle_meter.md
Name: gate_cycle_meter

Overview:
Measuring end of the gate-pulse scheme. Receives a single-shot gate pulse that was generated and timed in a foreign clock domain, and synchronises it into clk. Counts how many clk cycles the gate stays high, then presents the count through a valid/ready result interface. Used to compare clk against the reference clock that produced the gate, e.g. for frequency or ratio measurement.

Parameters:
WIDTH, 32, width of the count and of result; the count saturates at 2^WIDTH-1.
SYNC_STAGES, 2, number of flops in the gate_in synchroniser; legal values are 2 or more.
TIMEOUT, 65535, number of cycles the block waits for a rising edge before giving up; used only when GATE_TIMEOUT_EN is defined.

Ports:
clk  input  1  measured clock; every register of the block is in this domain.
resetn  input  1  asynchronous active-low reset.
gate_in  input  1  gate pulse from the foreign domain; asynchronous to clk.
start  input  1  single-cycle arm request; sampled only in IDLE.
busy  output  1  high while the block is armed or counting.
result  output  WIDTH  number of clk cycles the synchronised gate was high.
result_valid  output  1  result is available.
result_ready  input  1  consumer accepts the result.
overflow  output  1  the count saturated; qualified by result_valid.
timeout  output  1  present only with GATE_TIMEOUT_EN; qualified by result_valid.

Behaviour:
- Reset is asynchronous, active-low, on resetn; clock is clk.
- Reset state:
  - state is IDLE.
  - Synchroniser flops, count, result, result_valid, overflow, busy and timeout are all 0.
- gate_s is the output of the last synchroniser stage.
- gate_in is used nowhere except the first synchroniser stage.
- States are IDLE, ARM, WAIT_RISE, COUNT and DONE.
- IDLE: when start=1, go to ARM and clear count and overflow. All other inputs are ignored.
- ARM: if gate_s=0, go to WAIT_RISE. Otherwise stay in ARM. This discards any pulse already in progress when start arrives, so a partial pulse is never measured.
- WAIT_RISE: if gate_s=1, go to COUNT with count<=1.
- COUNT, gate_s=1:
  - If count is below 2^WIDTH-1, count<=count+1.
  - Otherwise count holds and overflow<=1.
- COUNT, gate_s=0: go to DONE with result<=count and result_valid<=1.
- Measured value: a gate that is high for exactly N clk cycles at gate_s gives result=N.
- Latency: result_valid rises SYNC_STAGES+1 clk cycles after the gate_in falling edge, for a gate_in that is synchronous to clk.
- DONE:
  - result, overflow and timeout are held stable while result_valid=1.
  - When result_valid=1 and result_ready=1, go to IDLE; result_valid is 0 on the next cycle.
  - result holds its last value after the handshake.
- start asserted in the same cycle as the handshake is ignored. start is never queued.
- Gate pulses that occur in DONE or IDLE are ignored.
- busy=1 in ARM, WAIT_RISE and COUNT; busy=0 in IDLE and DONE.
- Asserting resetn mid-operation clears everything to the reset state immediately. Any pending result is lost.

Optional Feature:
- Macro: GATE_TIMEOUT_EN.
- With the macro defined:
  - A wait counter clears on entry to ARM and increments in ARM and WAIT_RISE.
  - When the wait counter reaches TIMEOUT, go to DONE with result=0, timeout=1 and result_valid=1.
  - The timeout port exists.
- Without the macro: there is no wait counter and no timeout port. The block waits for a rising edge indefinitely.

Test Plan:
1. WIDTH=32, gate_in driven high for exactly 10 clk cycles after start → result=10, overflow=0, result_valid rises 3 cycles after the gate falls.
2. gate_in already high when start arrives, falls after 7 cycles, then a second pulse of 5 cycles → result=5; the first pulse is discarded.
3. WIDTH=4, gate pulse of 20 cycles → result=15, overflow=1.
4. result_ready held at 0 for 8 cycles after result_valid, with another gate pulse during DONE → result stable throughout, one handshake only, block returns to IDLE, the extra pulse is not measured.
5. resetn pulsed low during COUNT at count 6, then start with a 4-cycle pulse → outputs 0 during reset, then result=4.
6. GATE_TIMEOUT_EN defined, TIMEOUT=16, start with gate_in held low → result_valid at 16 wait cycles with result=0 and timeout=1.
